// File: rtl/qu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qu_pkg
// Description : Shared types and constants for the Qu processor front end:
//               PC/instruction types, the fetch packet, the fetch FSM state
//               type and the canonical NOP encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package qu_pkg;

  localparam int QU_PC_WIDTH     = 12;
  localparam int QU_PC_RESET_VAL = 0;
  localparam int QU_FETCH_DEPTH  = 2;

  typedef logic [31:0]            instr_t;
  typedef logic [QU_PC_WIDTH-1:0] qu_pc_t;

  localparam logic [2:0] FUNCT3_ADDI   = 3'b000;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  // I-type encoding for OP-IMM instructions.
  function automatic instr_t get_encoding_i_instr(
    input logic [2:0]  funct3,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [11:0] imm
  );
    return {imm, rs1, funct3, rd, OPCODE_OP_IMM};
  endfunction

  // addi x0, x0, 0
  localparam instr_t QU_NOP = get_encoding_i_instr(FUNCT3_ADDI, 5'd0, 5'd0, 12'd0);

  typedef enum logic [0:0] {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } qu_fetch_state_t;

  typedef struct packed {
    qu_pc_t pc;
    instr_t instr;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/qu_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : qu_fetch_fifo
// Description : Synchronous FIFO with registered storage and no fall-through.
//               Clear has priority over push; a pop while empty and a push
//               while full (without a simultaneous pop) are ignored.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               push_i/wdata_i - enqueue request and data
//               pop_i          - dequeue the head entry
//               clear_i        - empty the FIFO
//               rdata_o        - head entry (don't-care when empty)
//               full_o/empty_o/count_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module qu_fetch_fifo
  import qu_pkg::*;
#(
  parameter int  DEPTH = QU_FETCH_DEPTH,
  parameter type T     = fetch_pkt_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  T                             wdata_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output T                             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] wptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/qu_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : qu_ifetch
// Description : Qu instruction fetch stage. Owns the PC, issues word-aligned
//               requests to instruction memory under a credit limit, buffers
//               in-order responses and hands {pc, instr} to decode. A redirect
//               flushes the buffer; responses still in flight are drained and
//               dropped before fetching resumes.
// Ports       : clk, rst                       - clock, sync active-high reset
//               imem_req_valid/addr/ready      - fetch request channel
//               imem_rsp_valid/data            - in-order response channel
//               redirect_valid/pc              - new PC from downstream
//               out_valid/instr/pc/ready       - decode-side handshake
// Revision    : 1.0 - initial release
// ============================================================================
module qu_ifetch
  import qu_pkg::*;
#(
  parameter int                   PC_WIDTH     = QU_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]  PC_RESET_VAL = PC_WIDTH'(QU_PC_RESET_VAL),
  parameter int                   FIFO_DEPTH   = QU_FETCH_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  instr_t              imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                out_valid,
  output instr_t              out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  input  logic                out_ready
);

  localparam int OUT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [PC_WIDTH-1:0] pc_t;
  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } pkt_t;

  qu_fetch_state_t  state_q, state_d;
  pc_t              pc_q, pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;

  logic             req_fire;
  logic             rsp_fire;
  logic             rsp_push;
  logic [OUT_W:0]   credit_used;

  pkt_t             buf_wdata;
  pkt_t             buf_rdata;
  logic             buf_full;
  logic             buf_empty;
  logic [OUT_W-1:0] buf_count;

  pc_t              infl_pc;
  logic             infl_full;
  logic             infl_empty;
  logic [OUT_W-1:0] infl_count;
  logic             unused_ok;

  // Credit covers both in-flight requests and buffered entries so every
  // response always has a free slot. A same-cycle pop is deliberately ignored.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid = !rst && (state_q == FS_RUN)
                          && (credit_used < (OUT_W + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol violation and ignored.
  assign rsp_fire = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_push = rsp_fire && (state_q == FS_RUN);

  assign outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(rsp_fire);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    else if (req_fire)  pc_d = pc_q + PC_WIDTH'(4);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_RUN:   if (redirect_valid && (outstanding_d != '0)) state_d = FS_DRAIN;
      FS_DRAIN: if (outstanding_d == '0) state_d = FS_RUN;
      default:  state_d = FS_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FS_RUN;
      pc_q          <= PC_RESET_VAL;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  // PC of each accepted request, popped as its response returns. Never
  // cleared by a redirect: stale entries retire one-for-one with the drain.
  qu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pc_t)
  ) u_infl_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (rsp_fire),
    .clear_i (1'b0),
    .rdata_o (infl_pc),
    .full_o  (infl_full),
    .empty_o (infl_empty),
    .count_o (infl_count)
  );

  assign buf_wdata = '{pc: infl_pc, instr: imem_rsp_data};

  qu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pkt_t)
  ) u_buf_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_push),
    .wdata_i (buf_wdata),
    .pop_i   (out_valid && out_ready),
    .clear_i (redirect_valid),
    .rdata_o (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign out_valid = !buf_empty;
  assign out_instr = out_valid ? buf_rdata.instr : QU_NOP;
  assign out_pc    = out_valid ? buf_rdata.pc    : '0;

  assign unused_ok = &{1'b0, buf_full, infl_full, infl_empty, infl_count};

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rsp_valid && (outstanding_q == '0)));
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qu_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_qu_ifetch
// Description : Self-checking bench for qu_ifetch. A behavioural memory model
//               tags each accepted request with the redirect epoch; responses
//               of the current epoch become expected outputs, a monitor pops
//               and compares them on each decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qu_ifetch;
  import qu_pkg::*;

  localparam int DEPTH = QU_FETCH_DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [11:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc    = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [11:0] out_pc;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  qu_ifetch u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  typedef struct { logic [11:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [11:0] pc; logic [31:0] instr; } exp_t;

  req_t        memq[$];
  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          epoch = 0;
  int          cyc   = 0;
  logic [11:0] tb_pc = '0;
  bit          pop_seen = 0;

  int          rdy_pct = 100, ordy_pct = 100, redir_pct = 0, rsp_pct = 100, max_extra = 0;
  bit          force_redir = 0;
  logic [11:0] force_tgt = '0;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    if (a == 12'h000) return 32'h0050_0093;   // addi x1, x0, 5
    return {a ^ 12'h5A5, 8'h3C, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t        mon_e;
  bit          prev_stall = 0;
  bit          prev_redir = 0;
  logic [11:0] prev_pc    = '0;
  logic [31:0] prev_instr = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && !prev_redir) begin
        check("out_hold_valid", 64'(out_valid), 64'd1);
        check("out_hold_pc", 64'(out_pc), 64'(prev_pc));
        check("out_hold_instr", 64'(out_instr), 64'(prev_instr));
      end
      if (out_valid && out_ready) begin
        pop_seen = 1;
        n_pop++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got pc %0h instr %0h, expected no output", out_pc, out_instr);
        end else begin
          mon_e = expq.pop_front();
          check("out_pc", 64'(out_pc), 64'(mon_e.pc));
          check("out_instr", 64'(out_instr), 64'(mon_e.instr));
        end
      end else if (!out_valid) begin
        check("idle_instr", 64'(out_instr), 64'(QU_NOP));
        check("idle_pc", 64'(out_pc), 64'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_redir = redirect_valid;
      prev_pc    = out_pc;
      prev_instr = out_instr;
    end
  end

  // ---------------- model bookkeeping for one cycle ----------------
  task automatic book();
    bit   stale;
    bit   exp_req;
    req_t r;
    stale = 0;
    foreach (memq[i]) if (memq[i].epoch != epoch) stale = 1;
    exp_req = !stale && ((memq.size() + expq.size() + int'(pop_seen)) < DEPTH);
    check("req_valid", 64'(imem_req_valid), 64'(exp_req));
    if (imem_req_valid) check("req_addr", 64'(imem_req_addr), 64'(tb_pc));
    if (imem_rsp_valid) begin
      r = memq.pop_front();
      if (r.epoch == epoch && !redirect_valid)
        expq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
    end
    if (imem_req_valid && imem_req_ready) begin
      memq.push_back('{addr: tb_pc, epoch: epoch,
                       due: cyc + 1 + int'($urandom_range(max_extra))});
      tb_pc = tb_pc + 12'd4;
    end
    if (redirect_valid) begin
      expq.delete();
      epoch++;
      tb_pc = {redirect_pc[11:2], 2'b00};
    end
    pop_seen = 0;
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    out_ready      = ($urandom_range(99) < ordy_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_tgt;
      force_redir    = 0;
    end else begin
      redirect_valid = ($urandom_range(99) < redir_pct);
      redirect_pc    = ($urandom_range(3) == 0) ? (12'hFF0 | 12'($urandom_range(15)))
                                                : 12'($urandom);
    end
    if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    #1;
    book();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    memq.delete();
    expq.delete();
    epoch++;
    tb_pc    = 12'h000;
    pop_seen = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'(QU_NOP));
    check("rst_out_pc", 64'(out_pc), 64'd0);
  endtask

  task automatic knobs(input int rdy, input int ordy, input int redir, input int rsp, input int extra);
    rdy_pct = rdy; ordy_pct = ordy; redir_pct = redir; rsp_pct = rsp; max_extra = extra;
  endtask

  initial begin
    // Straight-line fetch with 1-cycle memory.
    do_reset();
    knobs(100, 100, 0, 100, 0);
    run(20);

    // Decode backpressure, then release.
    knobs(100, 0, 0, 100, 0);
    run(6);
    knobs(100, 100, 0, 100, 0);
    run(10);

    // Redirect to a misaligned target while two requests are in flight.
    knobs(100, 100, 0, 100, 3);
    run(4);
    force_redir = 1;
    force_tgt   = 12'h103;
    run(15);

    // PC wrap-around.
    knobs(100, 100, 0, 100, 0);
    force_redir = 1;
    force_tgt   = 12'hFF8;
    run(12);

    // Reset in the middle of stalled fetching.
    knobs(100, 0, 0, 100, 2);
    run(6);
    do_reset();
    knobs(100, 100, 0, 100, 0);
    run(10);

    // Randomised phases.
    knobs(70, 70, 5, 80, 2);
    run(800);
    knobs(90, 40, 15, 60, 3);
    run(800);
    do_reset();
    knobs(50, 90, 25, 90, 1);
    run(800);
    knobs(100, 100, 8, 100, 0);
    run(600);

    // Drain everything still in flight and verify forward progress.
    knobs(0, 100, 0, 100, 0);
    for (int i = 0; i < 100 && (memq.size() > 0 || expq.size() > 0); i++) cycle();
    n_cmp++;
    if (memq.size() > 0 || expq.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d in flight / %0d buffered, expected 0 / 0",
               memq.size(), expq.size());
    end
    check("progress", 64'(n_pop > 200), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
